recip_rom_pipe: RTL and testbench

Parametrised, pipelined reciprocal lookup for the accelerator datapath. Entry i holds min(2^FRAC_W − 1, floor(2^FRAC_W / (i+1))). For the default sizes the entries are 255, 128, 85, 64, 51, 42, 36, 32, 28, 25, 23, 21. Lookups use a valid/ready request and response handshake, pass through a two-stage registered pipeline with backpressure, and return a flagged zero for out-of-range addresses. The block sits between the accelerator controller and the multiplier stage that needs 1/n scaling.

---
 rtl/recip_rom_pipe.sv | 121 ++++++++++++
 tb/tb_recip_rom_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recip_rom_pipe.sv
// Purpose: pipelined reciprocal lookup. Entry i = min(2^FRAC_W-1, floor(2^FRAC_W/(i+1))).
//          Addresses >= DEPTH return zero data with the error flag set.
// Latency: two registered stages. A request accepted at edge N shows rsp_valid after edge N+1.
// Backpressure: valid/ready on both sides. req_ready = !s1_valid || !s2_valid || rsp_ready,
//          so rsp_ready reaches req_ready combinationally. Responses keep request order and are never dropped.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_addr is the table index
//   rsp_valid/rsp_ready   response handshake; rsp_data is the entry (0 on error), rsp_err is the oob flag
//   err_count             saturating (255) count of delivered error responses
module recip_rom_pipe #(
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [7:0]        err_count
);

    // The ROM covers the whole address space so any ADDR_W-bit index is
    // legal; slots at or above DEPTH are filled with zero and never used
    // for a valid response because the oob flag forces zero anyway.
    localparam int              ROM_N     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Elaboration-time entry computation. Entry 0 would be exactly
    // 2^FRAC_W, which needs FRAC_W+1 bits, so the result is clamped.
    function automatic logic [DATA_W-1:0] recip_entry(input int idx);
        logic [63:0] scale;
        logic [63:0] quot;
        scale = 64'd1 << FRAC_W;
        quot  = scale / 64'(idx + 1);
        if (quot > scale - 64'd1) begin
            quot = scale - 64'd1;
        end
        return quot[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] rom [ROM_N];

    for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
        assign rom[gi] = (gi < DEPTH) ? recip_entry(gi) : '0;
    end

    // Pipeline state
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic              s1_oob;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_err;

    logic              req_oob;
    logic              s2_free;
    logic              rsp_fire;

    // No wrap: any index at or beyond DEPTH is an error.
    assign req_oob  = ({1'b0, req_addr} >= DEPTH_LIM);

    // S2 can take new contents when empty or when its response leaves now.
    assign s2_free  = !s2_valid || rsp_ready;
    assign rsp_fire = s2_valid && rsp_ready;

    // S1 can take a request when empty or when it drains into S2 this edge.
    assign req_ready = !s1_valid || s2_free;

    // Stage 1: capture address and range check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_oob   <= 1'b0;
        end else if (req_ready) begin
            s1_valid <= req_valid;
            if (req_valid) begin
                s1_addr <= req_addr;
                s1_oob  <= req_oob;
            end
        end
    end

    // Stage 2: table read. Data and flag only change when S2 advances,
    // which keeps the response stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_oob ? '0 : rom[s1_addr];
                s2_err  <= s1_oob;
            end
        end
    end

    // Error counter counts delivered responses, not accepted requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (rsp_fire && s2_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_err   = s2_err;

endmodule

// File: tb/tb_recip_rom_pipe.sv
// Testbench for recip_rom_pipe: default instance driven with directed and
// random traffic against a queue-based reference model, plus a second
// instance with DEPTH=16, FRAC_W=10 swept once.
module tb_recip_rom_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // Default instance
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  err_count;

    // DEPTH=16, FRAC_W=10 instance
    logic        req_valid2;
    logic        req_ready2;
    logic [3:0]  req_addr2;
    logic        rsp_valid2;
    logic        rsp_ready2;
    logic [15:0] rsp_data2;
    logic        rsp_err2;
    logic [7:0]  err_count2;

    recip_rom_pipe #(.DEPTH(12), .ADDR_W(4), .DATA_W(16), .FRAC_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .err_count(err_count)
    );

    recip_rom_pipe #(.DEPTH(16), .ADDR_W(4), .DATA_W(16), .FRAC_W(10)) u_dut16 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_data(rsp_data2),
        .rsp_err(rsp_err2), .err_count(err_count2)
    );

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state: expected responses in request order, each
    // encoded as {err, data[15:0]}, and the expected error counter.
    int          exp_q[$];
    int          model_err = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_err = 1'b0;
    logic        last_req_fire = 1'b0;

    function automatic int ref_recip(input int a, input int depth, input int frac);
        int q;
        if (a >= depth) return 0;
        q = (1 << frac) / (a + 1);
        if (q > (1 << frac) - 1) q = (1 << frac) - 1;
        return q;
    endfunction

    function automatic int expect_of(input int a);
        return ((a >= 12) ? 32'h10000 : 0) | ref_recip(a, 12, 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle of the default instance: sample at the falling edge,
    // score any handshakes, then advance to just after the rising edge.
    task automatic cycle();
        int e;
        @(negedge clk);
        chk("err_count", err_count, model_err);
        chk("req_ready", req_ready, (exp_q.size() < 2) || rsp_ready);
        if (prev_stall) begin
            chk("stall_valid", rsp_valid, 1'b1);
            chk("stall_data", rsp_data, prev_data);
            chk("stall_err", rsp_err, prev_err);
        end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e[15:0]);
                chk("rsp_err", rsp_err, e[16]);
                if (e[16] && model_err < 255) model_err++;
            end
        end
        last_req_fire = req_valid && req_ready;
        if (last_req_fire) exp_q.push_back(expect_of(int'(req_addr)));
        prev_stall = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
        prev_err   = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        for (int t = 0; t < 50; t++) begin
            cycle();
            if (last_req_fire) break;
        end
        chk("send_accept", last_req_fire, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (exp_q.size() == 0) break;
            cycle();
        end
        chk("drain_empty", exp_q.size(), 0);
        cycle();
        chk("idle_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got2 [16];
        int n_got2;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b0;
        req_valid2 = 1'b0;
        req_addr2  = '0;
        rsp_ready2 = 1'b0;

        // Reset state
        #2;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 16'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back sweep 0..11: first response two edges after the
        // first request is presented, then one per cycle.
        rsp_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            req_valid = (k < 12);
            req_addr  = k[3:0];
            chk("sweep_valid", rsp_valid, (k >= 2) && (k < 14));
            cycle();
        end
        req_valid = 1'b0;
        chk("sweep_drained", exp_q.size(), 0);

        // Out-of-range addresses 12 and 15
        send(4'd12);
        send(4'd15);
        drain();
        chk("oob_err_count", err_count, 8'd2);

        // Backpressure: three requests with the consumer stalled
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 4'd3;
        cycle();
        req_addr  = 4'd7;
        cycle();
        req_addr  = 4'd9;
        chk("bp_full_ready", req_ready, 1'b0);
        chk("bp_head_valid", rsp_valid, 1'b1);
        chk("bp_head_data", rsp_data, 16'd64);
        for (int t = 0; t < 4; t++) cycle();
        chk("bp_hold_data", rsp_data, 16'd64);
        rsp_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cycle();
            if (last_req_fire) break;
        end
        chk("bp_third_accept", last_req_fire, 1'b1);
        drain();

        // Random traffic across the full address space
        for (int t = 0; t < 500; t++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain();

        // Saturation of the error counter
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            req_addr = 4'($urandom_range(12, 15));
            cycle();
        end
        drain();
        chk("sat_err_count", err_count, 8'd255);
        send(4'd13);
        drain();
        chk("sat_err_hold", err_count, 8'd255);

        // Reset with two requests in flight
        rsp_ready = 1'b0;
        send(4'd5);
        send(4'd6);
        chk("inflight_count", exp_q.size(), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_err_count", err_count, 8'd0);
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_rsp_err", rsp_err, 1'b0);
        exp_q.delete();
        model_err  = 0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        send(4'd1);
        drain();

        // Second parameter set: DEPTH=16, FRAC_W=10
        n_got2 = 0;
        rsp_ready2 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            req_valid2 = (k < 16);
            req_addr2  = k[3:0];
            @(negedge clk);
            if (rsp_valid2 && rsp_ready2) begin
                if (n_got2 < 16) begin
                    got2[n_got2] = int'(rsp_data2);
                    chk("p2_data", rsp_data2, ref_recip(n_got2, 16, 10));
                end
                chk("p2_err", rsp_err2, 1'b0);
                n_got2++;
            end
            @(posedge clk);
            #1;
        end
        req_valid2 = 1'b0;
        chk("p2_count", n_got2, 16);
        chk("p2_entry0", got2[0], 1023);
        chk("p2_entry1", got2[1], 512);
        chk("p2_entry15", got2[15], 64);
        chk("p2_err_count", err_count2, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
